// File: rtl/fp_posit_mul_serial.sv
// Bit-serial FP16 x posit multiplier: the weight posit arrives MSB-first, one bit per accepted
// beat, and the significand product is built by shift-add as the fraction bits stream in.
module fp_posit_mul_serial #(
  parameter int ACT_WIDTH = 16,
  parameter int EXP_WIDTH = 5,
  parameter int MAN_WIDTH = 10,
  parameter int MAX_PBITS = 8,
  parameter int ES_MAX    = 2
) (
  input  logic                                                   clk,
  input  logic                                                   rst,
  input  logic [ACT_WIDTH-1:0]                                   act,
  input  logic                                                   w,
  input  logic                                                   valid,
  input  logic                                                   set,
  input  logic [$clog2(MAX_PBITS+1)-1:0]                         precision,
  input  logic [$clog2(ES_MAX+1)-1:0]                            es,
  output logic                                                   sign_out,
  output logic [EXP_WIDTH+ES_MAX+$clog2(MAX_PBITS)+1-1:0]        exp_out,
  output logic [MAN_WIDTH+MAX_PBITS-3+2-1:0]                     man_out,
  output logic                                                   zero_out,
  output logic                                                   nar_out,
  output logic                                                   out_valid
);
  localparam int FRAC_W    = MAX_PBITS - 3;
  localparam int MAN_OUT_W = MAN_WIDTH + FRAC_W + 2;
  localparam int EXP_OUT_W = EXP_WIDTH + ES_MAX + $clog2(MAX_PBITS) + 1;
  localparam int PW        = $clog2(MAX_PBITS + 1);
  localparam int EW        = $clog2(ES_MAX + 1);
  localparam int AW        = MAN_WIDTH + 1;

  localparam logic [PW-1:0] ONE_P   = PW'(1);
  localparam logic [PW-1:0] MIN_N   = PW'(3);
  localparam logic [PW-1:0] MAX_N   = PW'(MAX_PBITS);
  localparam logic [PW-1:0] FRAC_WL = PW'(FRAC_W);
  localparam logic [EW-1:0] ONE_E   = EW'(1);
  localparam logic [EW-1:0] MAX_ES  = EW'(ES_MAX);

  // Decode phase; PH_SIGN holds exactly when the bit counter is 0.
  localparam logic [1:0] PH_SIGN   = 2'd0;
  localparam logic [1:0] PH_REGIME = 2'd1;
  localparam logic [1:0] PH_EXP    = 2'd2;
  localparam logic [1:0] PH_FRAC   = 2'd3;

  logic [PW-1:0]        n_q, cnt_q, cnt_d, k_q, k_d, m_q, m_d;
  logic [EW-1:0]        es_q, ecnt_q, ecnt_d;
  logic [1:0]           phase_q, phase_d;
  logic [ES_MAX-1:0]    e_q, e_d;
  logic [EXP_WIDTH-1:0] aexp_q, aexp_d;
  logic [AW-1:0]        a_q, a_d;
  logic [MAN_OUT_W-1:0] acc_q, acc_d;
  logic                 azero_q, azero_d, sgn_q, sgn_d, wsign_q, wsign_d;
  logic                 r0_q, r0_d, any_q, any_d;

  logic                 sign_o_q, zero_o_q, nar_o_q, out_valid_q;
  logic [EXP_OUT_W-1:0] exp_o_q;
  logic [MAN_OUT_W-1:0] man_o_q;

  logic [PW-1:0]        n_cfg, n_cur;
  logic [EW-1:0]        es_cfg, es_cur;
  logic                 load_cfg, last, hidden;

  assign n_cfg    = (precision < MIN_N) ? MIN_N : ((precision > MAX_N) ? MAX_N : precision);
  assign es_cfg   = (es > MAX_ES) ? MAX_ES : es;
  assign load_cfg = set && (cnt_q == '0);
  assign n_cur    = load_cfg ? n_cfg : n_q;
  assign es_cur   = load_cfg ? es_cfg : es_q;
  assign last     = (cnt_q == (n_cur - ONE_P));
  assign hidden   = |act[ACT_WIDTH-2 -: EXP_WIDTH];

  always_comb begin
    cnt_d = cnt_q; phase_d = phase_q; k_d = k_q; m_d = m_q; ecnt_d = ecnt_q;
    e_d = e_q; aexp_d = aexp_q; a_d = a_q; acc_d = acc_q; azero_d = azero_q;
    sgn_d = sgn_q; wsign_d = wsign_q; r0_d = r0_q; any_d = any_q;
    if (valid) begin
      cnt_d = last ? '0 : cnt_q + ONE_P;
      case (phase_q)
        PH_SIGN: begin
          sgn_d   = act[ACT_WIDTH-1] ^ w;
          wsign_d = w;
          aexp_d  = act[ACT_WIDTH-2 -: EXP_WIDTH];
          a_d     = {hidden, act[MAN_WIDTH-1:0]};
          acc_d   = {{(MAN_OUT_W-AW){1'b0}}, hidden, act[MAN_WIDTH-1:0]};
          azero_d = !hidden && (act[MAN_WIDTH-1:0] == '0);
          k_d = '0; m_d = '0; ecnt_d = '0; e_d = '0; r0_d = 1'b0; any_d = 1'b0;
          phase_d = PH_REGIME;
        end
        PH_REGIME: begin
          any_d = any_q | w;
          if (cnt_q == ONE_P) begin
            r0_d = w;
            k_d  = ONE_P;
          end else if (w == r0_q) begin
            k_d = k_q + ONE_P;
          end else begin
            phase_d = (es_cur == '0) ? PH_FRAC : PH_EXP;
          end
        end
        PH_EXP: begin
          any_d  = any_q | w;
          e_d    = ES_MAX'({e_q, w});
          ecnt_d = ecnt_q + ONE_E;
          if (ecnt_d == es_cur) phase_d = PH_FRAC;
        end
        default: begin
          any_d = any_q | w;
          acc_d = (acc_q << 1) + (w ? {{(MAN_OUT_W-AW){1'b0}}, a_q} : '0);
          m_d   = m_q + ONE_P;
        end
      endcase
      if (last) phase_d = PH_SIGN;
    end
  end

  // Final result, formed from this beat's next-state values so the last bit is included.
  logic [EXP_OUT_W-1:0] kx, r_s, scale, exp_calc, exp_nxt;
  logic [ES_MAX-1:0]    e_fin;
  logic [MAN_OUT_W-1:0] man_nxt;
  logic                 nar_nxt, zero_nxt;

  always_comb begin
    kx       = {{(EXP_OUT_W-PW){1'b0}}, k_d};
    r_s      = r0_d ? (kx - EXP_OUT_W'(1)) : (-kx);
    e_fin    = e_d << (es_cur - ecnt_d);
    scale    = (r_s << es_cur) + {{(EXP_OUT_W-ES_MAX){1'b0}}, e_fin};
    exp_calc = {{(EXP_OUT_W-EXP_WIDTH){1'b0}}, aexp_d} + scale;
    nar_nxt  = wsign_d && !any_d;
    zero_nxt = !nar_nxt && (!any_d || azero_d);
    exp_nxt  = (nar_nxt || zero_nxt) ? '0 : exp_calc;
    man_nxt  = (nar_nxt || zero_nxt) ? '0 : (acc_d << (FRAC_WL - m_d));
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      n_q <= MAX_N; es_q <= '0; cnt_q <= '0; phase_q <= PH_SIGN;
      k_q <= '0; m_q <= '0; ecnt_q <= '0; e_q <= '0; aexp_q <= '0; a_q <= '0;
      acc_q <= '0; azero_q <= 1'b0; sgn_q <= 1'b0; wsign_q <= 1'b0; r0_q <= 1'b0; any_q <= 1'b0;
      sign_o_q <= 1'b0; exp_o_q <= '0; man_o_q <= '0; zero_o_q <= 1'b0; nar_o_q <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      if (load_cfg) begin
        n_q  <= n_cfg;
        es_q <= es_cfg;
      end
      cnt_q <= cnt_d; phase_q <= phase_d; k_q <= k_d; m_q <= m_d; ecnt_q <= ecnt_d;
      e_q <= e_d; aexp_q <= aexp_d; a_q <= a_d; acc_q <= acc_d; azero_q <= azero_d;
      sgn_q <= sgn_d; wsign_q <= wsign_d; r0_q <= r0_d; any_q <= any_d;
      out_valid_q <= valid && last;
      if (valid && last) begin
        sign_o_q <= sgn_d;
        exp_o_q  <= exp_nxt;
        man_o_q  <= man_nxt;
        zero_o_q <= zero_nxt;
        nar_o_q  <= nar_nxt;
      end
    end
  end

  assign sign_out  = sign_o_q;
  assign exp_out   = exp_o_q;
  assign man_out   = man_o_q;
  assign zero_out  = zero_o_q;
  assign nar_out   = nar_o_q;
  assign out_valid = out_valid_q;
endmodule

// File: doc/fp_posit_mul_serial.md
# fp_posit_mul_serial

Bit-serial multiplier of an IEEE-style half-precision activation by a variable-width posit weight streamed MSB-first, one bit per accepted cycle. Generalises the first-generation FP×posit multiplier:
- runtime-selectable posit width and es;
- full regime/exponent/fraction decode;
- shift-add mantissa product built as fraction bits arrive;
- zero/NaR flags and a registered output-valid strobe.

It sits between the weight bit-stream buffer and the fixed-point accumulator of the MAC.

## Interface
Parameters:
- ACT_WIDTH, 16, activation width (1 sign + EXP_WIDTH + MAN_WIDTH)
- EXP_WIDTH, 5, activation exponent field width
- MAN_WIDTH, 10, activation mantissa field width
- MAX_PBITS, 8, maximum posit width n (≥3)
- ES_MAX, 2, maximum posit es
- Derived: FRAC_W = MAX_PBITS-3; MAN_OUT_W = MAN_WIDTH+FRAC_W+2; EXP_OUT_W = EXP_WIDTH+ES_MAX+$clog2(MAX_PBITS)+1

Ports:
- Clocking and reset: one clock; reset is synchronous and active-low (clk, rst).
- clk  in  1  clock
- rst  in  1  synchronous active-low reset
- act  in  ACT_WIDTH  activation {sign, exp, man}; sampled on the bit-0 beat
- w  in  1  weight bit, MSB first
- valid  in  1  w is valid this cycle; low = stall
- set  in  1  load precision/es; honoured only when idle (bit counter = 0)
- precision  in  $clog2(MAX_PBITS+1)  posit width n
- es  in  $clog2(ES_MAX+1)  posit es
- sign_out  out  1  product sign
- exp_out  out  EXP_OUT_W  signed, biased (activation bias) product exponent
- man_out  out  MAN_OUT_W  product significand, 2 integer bits + MAN_WIDTH+FRAC_W fraction bits
- zero_out  out  1  product is zero
- nar_out  out  1  weight is NaR
- out_valid  out  1  one-cycle strobe: outputs valid

## Operation
Weight encoding:
- Bit 0 is the sign.
- Bits 1..n-1 are the magnitude posit body; it is not two's-complemented.
- Encoding 100…0 is NaR; 000…0 is zero.

Configuration:
- precision clamped to [3, MAX_PBITS]; es clamped to ES_MAX.
- set while a word is in progress is ignored.

Bit counter cnt:
- Increments on each valid beat; wraps to 0 after beat n-1.
- Back-to-back words are allowed.

States, selected by cnt and registered flags:
- SIGN (cnt=0):
  - latch act; sign_out_nxt = act sign ^ w;
  - init acc = {hidden, act man}, where hidden = (act exp ≠ 0);
  - clear the run length k and the any-one flag.
- REGIME:
  - cnt=1 records the first regime bit r0 and sets k=1.
  - Each later bit equal to r0 increments k.
  - The first opposite bit terminates the regime and moves to EXP.
  - Reaching the word end with no opposite bit also terminates the regime.
  - Regime value r = k-1 if r0=1, else r = -k.
- EXP: next es bits shift into e, MSB first. Bits truncated by the word end read as 0.
- FRAC:
  - remaining m bits each perform acc = (acc<<1) + (w ? A : 0), where A = latched {hidden, man};
  - count m.
- Any-one flag tracks whether any bit 1..n-1 is 1.

At the last beat:
- scale = r·2^es + e.
- exp_out = act exp + scale, sign-extended to EXP_OUT_W.
- man_out = acc << (FRAC_W-m).
- zero_out = !any_one, or act exp=0 and man=0.
- nar_out = sign bit 1 and !any_one.
- If zero_out or nar_out: man_out=0, exp_out=0.
- nar_out has priority over zero_out. A NaR weight with a zero activation gives nar_out=1, zero_out=0.

Subnormal activation: hidden=0, exponent used as-is. No normalisation is performed here.

## Timing
- Reset (rst=0 at a clk edge): all outputs 0, cnt=0, precision=MAX_PBITS, es=0. Takes effect from that edge. A partial word is discarded with no out_valid.
- Latency: out_valid high in the cycle after the edge that accepts beat n-1. Outputs hold until the next word completes.
- out_valid is high for exactly one cycle per word.
- valid=0 freezes all internal state. Any number of stall cycles is tolerated.
- act is sampled only on the bit-0 beat; later changes are don't-care.
- set and valid together at cnt=0: new precision/es apply to the word beginning that cycle.

## Test plan
- n=8, es=0, act=16'h3C00, w=0_10_00000 → sign 0, exp_out 15, man_out 17'h08000, flags 0, out_valid 1 cycle after beat 7.
- n=8, es=0, act=16'h3E00, w=0_110_1000 → exp_out 16, man_out 17'h12000 (2.25).
- n=8, es=1, act=16'hBC00, w=1_01_1_0100 → sign 0, exp_out 14, man_out 17'h0A000 (+0.625).
- Special words:
  - w=00000000 → zero_out 1, man/exp 0.
  - w=10000000 → nar_out 1.
  - w=0_1111111, es=0 → exp_out 21 (r=6).
- Stalls and set:
  - Repeat test 2 with valid low 3 cycles after beat 3 and set asserted mid-word with precision=4 → identical outputs, out_valid after 8 valid beats.
  - Next word then uses n=8.
- Assert rst=0 at beat 4 → outputs 0, no out_valid. A following full word from test 1 yields the test-1 result.
